strip_frame_sequencer: RTL and testbench

- Frame scheduler for the WS2812B character-matrix strip.
- Owns refresh timing and walks every LED of the NUM_CHARS x CHAR_LEDS matrix.
- Addresses the character/color lookup via `char_slot`, then streams one 24-bit pixel per LED into the `ws2812b` driver using its valid/ready/latch handshake.
- Sits between the text/color buffers and `ws2812b`, replacing ad-hoc top-level sequencing.

---
 rtl/strip_frame_sequencer_pkg.sv | 23 ++
 rtl/strip_frame_sequencer_refresh_prescaler.sv | 40 ++++
 rtl/strip_frame_sequencer.sv | 171 +++++++++++++++++
 tb/tb_strip_frame_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strip_frame_sequencer_pkg.sv
// Shared types and default geometry for the WS2812B character-matrix strip sequencer.
package strip_pkg;

  localparam int DEF_NUM_CHARS = 4;
  localparam int DEF_CHAR_LEDS = 35;
  localparam int DEF_PIX_W     = 24;
  localparam int CHAN_W        = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_READY,
    WAIT_STARTED
  } state_t;

  // GRB wire order used by the WS2812B
  typedef struct packed {
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] b;
  } pixel_t;

endpackage

// File: rtl/strip_frame_sequencer_refresh_prescaler.sv
// Free-running refresh divider with a single-level pending flag for ticks that land mid-frame.
module refresh_prescaler #(
  parameter int REFRESH_DIV_LOG2 = 17
) (
  input  logic clk20,
  input  logic reset,
  input  logic frame_en,
  input  logic busy,
  input  logic clear_pending,
  output logic start_req
);

  logic [REFRESH_DIV_LOG2-1:0] cnt;
  logic                        tick;
  logic                        pending;

  assign tick = frame_en & (&cnt);

  always_ff @(posedge clk20 or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Only one frame can be owed; extra ticks while busy collapse into it.
  always_ff @(posedge clk20 or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (clear_pending) begin
      pending <= 1'b0;
    end else if (tick && busy) begin
      pending <= 1'b1;
    end
  end

  assign start_req = frame_en & (tick | pending);

endmodule

// File: rtl/strip_frame_sequencer.sv
// Frame scheduler: walks every LED of the character matrix and streams pixels to ws2812b.
// Optional STRIP_DIM_EN adds dim_shift, a per-frame right shift applied to each lit channel.
module strip_frame_sequencer
  import strip_pkg::*;
#(
  parameter int NUM_CHARS        = DEF_NUM_CHARS,
  parameter int CHAR_LEDS        = DEF_CHAR_LEDS,
  parameter int PIX_W            = DEF_PIX_W,
  parameter int REFRESH_DIV_LOG2 = 17
) (
  input  logic                         clk20,
  input  logic                         reset,
  input  logic                         frame_en,
  output logic [$clog2(NUM_CHARS)-1:0] char_slot,
  input  logic [CHAR_LEDS-1:0]         char_bits,
  input  logic [PIX_W-1:0]             char_color,
  output logic [PIX_W-1:0]             pix_data,
  output logic                         pix_valid,
  output logic                         pix_latch,
  input  logic                         pix_ready,
`ifdef STRIP_DIM_EN
  input  logic [2:0]                   dim_shift,
`endif
  output logic                         frame_busy,
  output logic                         frame_done
);

  localparam int TOTAL  = NUM_CHARS * CHAR_LEDS;
  localparam int LED_W  = $clog2(TOTAL + 1);
  localparam int BIT_W  = $clog2(CHAR_LEDS);
  localparam int SLOT_W = $clog2(NUM_CHARS);

  localparam logic [LED_W-1:0]  LED_LAST  = LED_W'(TOTAL - 1);
  localparam logic [LED_W-1:0]  LED_TOTAL = LED_W'(TOTAL);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(CHAR_LEDS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CHARS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [LED_W-1:0] led_idx;
  logic [BIT_W-1:0] bit_idx;
  logic             start_req;
  logic             busy;
  logic             clear_pending;
  logic             load_en;
  logic             adv_en;
  logic             rel_en;
  logic             done_en;
  pixel_t           color_px;
  pixel_t           lit_px;

  refresh_prescaler #(
    .REFRESH_DIV_LOG2(REFRESH_DIV_LOG2)
  ) u_prescaler (
    .clk20        (clk20),
    .reset        (reset),
    .frame_en     (frame_en),
    .busy         (busy),
    .clear_pending(clear_pending),
    .start_req    (start_req)
  );

  assign color_px = pixel_t'(char_color);

`ifdef STRIP_DIM_EN
  logic [2:0] dim_q;

  function automatic pixel_t dim_pixel(input pixel_t px, input logic [2:0] sh);
    pixel_t res;
    res.g = px.g >> sh;
    res.r = px.r >> sh;
    res.b = px.b >> sh;
    return res;
  endfunction

  // Brightness is frozen for the whole frame so one refresh never mixes levels.
  always_ff @(posedge clk20 or posedge reset) begin
    if (reset) begin
      dim_q <= '0;
    end else if (clear_pending) begin
      dim_q <= dim_shift;
    end
  end

  assign lit_px = dim_pixel(color_px, dim_q);
`else
  assign lit_px = color_px;
`endif

  always_ff @(posedge clk20 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (start_req) state_nxt = LOAD;
      LOAD:         state_nxt = WAIT_READY;
      WAIT_READY:   if (pix_ready) state_nxt = WAIT_STARTED;
      WAIT_STARTED: if (!pix_ready) state_nxt = (led_idx < LED_TOTAL) ? LOAD : IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state and the handshake.
  always_comb begin
    busy          = (state != IDLE);
    clear_pending = 1'b0;
    load_en       = 1'b0;
    adv_en        = 1'b0;
    rel_en        = 1'b0;
    done_en       = 1'b0;
    case (state)
      IDLE:         clear_pending = start_req;
      LOAD:         load_en = 1'b1;
      WAIT_READY:   adv_en = pix_ready;
      WAIT_STARTED: begin
        rel_en  = !pix_ready;
        done_en = !pix_ready && (led_idx >= LED_TOTAL);
      end
      default:      ;
    endcase
  end

  assign frame_busy = busy;

  // char_slot moves on the WAIT_READY exit, leaving WAIT_STARTED as a full ROM settle cycle.
  always_ff @(posedge clk20 or posedge reset) begin
    if (reset) begin
      led_idx    <= '0;
      bit_idx    <= '0;
      char_slot  <= '0;
      pix_data   <= '0;
      pix_valid  <= 1'b0;
      pix_latch  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_en;
      if (!busy) begin
        led_idx   <= '0;
        bit_idx   <= '0;
        char_slot <= '0;
        pix_latch <= 1'b0;
      end
      if (load_en) begin
        pix_data  <= char_bits[bit_idx] ? lit_px : '0;
        pix_latch <= (led_idx == LED_LAST);
      end
      if (adv_en) begin
        pix_valid <= 1'b1;
        led_idx   <= led_idx + 1'b1;
        if (bit_idx == BIT_LAST) begin
          bit_idx <= '0;
          if (char_slot != SLOT_LAST) begin
            char_slot <= char_slot + 1'b1;
          end
        end else begin
          bit_idx <= bit_idx + 1'b1;
        end
      end
      if (rel_en) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_strip_frame_sequencer.sv
// Bench for strip_frame_sequencer: ws2812b ready model, ROM model and per-pixel reference checks.
module tb_strip_frame_sequencer;

  localparam int NC  = 2;
  localparam int CL  = 35;
  localparam int TOT = NC * CL;
  localparam int CAP = 4096;

  logic        clk20 = 1'b0;
  logic        reset;
  logic        frame_en;
  logic [0:0]  char_slot;
  logic [34:0] char_bits;
  logic [23:0] char_color;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_latch;
  logic        pix_ready = 1'b1;
  logic        frame_busy;
  logic        frame_done;
`ifdef STRIP_DIM_EN
  logic [2:0]  dim_shift;
`endif

  logic [34:0] rom_bits [NC];
  logic [23:0] rom_color[NC];

  int checks   = 0;
  int errors   = 0;
  int tot_px   = 0;
  int done_cnt = 0;
  bit prev_v   = 1'b0;
  bit stall    = 1'b0;
  int hold_len = 5;
  int hold     = 0;

  logic [23:0] cap_pix  [CAP];
  logic        cap_latch[CAP];
  int          cap_slot [CAP];

  typedef struct {
    logic [34:0] b0;
    logic [34:0] b1;
    logic [23:0] c0;
    logic [23:0] c1;
    int          k;
    logic [23:0] exp_pix;
    logic        exp_latch;
  } vec_t;

  assign char_bits  = rom_bits[char_slot];
  assign char_color = rom_color[char_slot];

  always #25 clk20 = ~clk20;

  strip_frame_sequencer #(
    .NUM_CHARS       (NC),
    .CHAR_LEDS       (CL),
    .PIX_W           (24),
    .REFRESH_DIV_LOG2(4)
  ) dut (
    .clk20     (clk20),
    .reset     (reset),
    .frame_en  (frame_en),
    .char_slot (char_slot),
    .char_bits (char_bits),
    .char_color(char_color),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_latch (pix_latch),
    .pix_ready (pix_ready),
`ifdef STRIP_DIM_EN
    .dim_shift (dim_shift),
`endif
    .frame_busy(frame_busy),
    .frame_done(frame_done)
  );

  // ws2812b stand-in: ready drops after accepting a pixel and returns hold_len cycles later.
  always @(negedge clk20) begin
    if (reset) begin
      pix_ready = 1'b1;
      hold      = 0;
    end else if (stall) begin
      pix_ready = 1'b0;
      hold      = 0;
    end else if (hold > 0) begin
      hold = hold - 1;
      if (hold == 0) pix_ready = 1'b1;
    end else if (!pix_ready) begin
      pix_ready = 1'b1;
    end else if (pix_valid) begin
      pix_ready = 1'b0;
      hold      = hold_len;
    end
  end

  always @(negedge clk20) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (pix_valid && !prev_v) begin
        if (tot_px < CAP) begin
          cap_pix[tot_px]   = pix_data;
          cap_latch[tot_px] = pix_latch;
          cap_slot[tot_px]  = int'(char_slot);
        end
        tot_px = tot_px + 1;
      end
      prev_v = pix_valid;
      if (frame_done) done_cnt = done_cnt + 1;
    end
  end

  function automatic logic [23:0] model_pix(input int k);
    int          s;
    int          b;
    logic [23:0] c;
    s = k / CL;
    b = k % CL;
    c = rom_color[s];
`ifdef STRIP_DIM_EN
    c = {c[23:16] >> dim_shift, c[15:8] >> dim_shift, c[7:0] >> dim_shift};
`endif
    return rom_bits[s][b] ? c : 24'h0;
  endfunction

  function automatic int model_slot(input int k);
    int s;
    s = (k + 1) / CL;
    if (s > NC - 1) s = NC - 1;
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk20);
    #1;
  endtask

  task automatic wait_busy(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      step();
      n = n + 1;
      if (frame_busy) break;
    end
    check("start_within_bound", 64'(frame_busy), 64'd1);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (n < limit) begin
      step();
      n = n + 1;
      if (frame_done) break;
    end
    check("done_within_bound", 64'(frame_done), 64'd1);
  endtask

  task automatic wait_px(input int base, input int count, input int limit);
    int n;
    n = 0;
    while (n < limit && (tot_px - base) < count) begin
      step();
      n = n + 1;
    end
    check("pixels_within_bound", 64'((tot_px - base) >= count), 64'd1);
  endtask

  task automatic check_frame(input int base, input int d0, input string tag);
    check({tag, "_npix"}, 64'(tot_px - base), 64'(TOT));
    check({tag, "_ndone"}, 64'(done_cnt - d0), 64'd1);
    for (int k = 0; k < TOT; k++) begin
      if (base + k >= CAP) break;
      check($sformatf("%s_pix%0d", tag, k), 64'(cap_pix[base + k]), 64'(model_pix(k)));
      check($sformatf("%s_latch%0d", tag, k), 64'(cap_latch[base + k]), 64'(k == TOT - 1));
      check($sformatf("%s_slot%0d", tag, k), 64'(cap_slot[base + k]), 64'(model_slot(k)));
    end
  endtask

  task automatic run_frame(output int base, input string tag);
    int n;
    int d0;
    d0       = done_cnt;
    base     = tot_px;
    frame_en = 1'b1;
    wait_busy(40, n);
    frame_en = 1'b0;
    wait_done(3000);
    check_frame(base, d0, tag);
  endtask

  initial begin
    #(50 * 60000);
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    int   n;
    int   base;
    int   d0;
    int   b2;
    int   busy_seen;

    tbl[0] = '{35'h1, 35'h0, 24'h00FF00, 24'h00FF00, 0, 24'h00FF00, 1'b0};
    tbl[1] = '{35'h1, 35'h0, 24'h00FF00, 24'h00FF00, 1, 24'h000000, 1'b0};
    tbl[2] = '{35'h1, 35'h0, 24'h00FF00, 24'h00FF00, 69, 24'h000000, 1'b1};
    tbl[3] = '{35'h0, 35'h400000000, 24'h000000, 24'h123456, 69, 24'h123456, 1'b1};
    tbl[4] = '{35'h7FFFFFFFF, 35'h0, 24'hABCDEF, 24'h000000, 34, 24'hABCDEF, 1'b0};
    tbl[5] = '{35'h7FFFFFFFF, 35'h2, 24'hABCDEF, 24'hFF0000, 36, 24'hFF0000, 1'b0};
    tbl[6] = '{35'h7FFFFFFFF, 35'h2, 24'hABCDEF, 24'hFF0000, 35, 24'h000000, 1'b0};

    reset    = 1'b1;
    frame_en = 1'b0;
`ifdef STRIP_DIM_EN
    dim_shift = 3'd0;
`endif
    rom_bits[0]  = 35'h1;
    rom_bits[1]  = 35'h0;
    rom_color[0] = 24'h00FF00;
    rom_color[1] = 24'h00FF00;
    repeat (3) step();

    check("rst_pix_data", 64'(pix_data), 64'd0);
    check("rst_pix_valid", 64'(pix_valid), 64'd0);
    check("rst_pix_latch", 64'(pix_latch), 64'd0);
    check("rst_char_slot", 64'(char_slot), 64'd0);
    check("rst_frame_busy", 64'(frame_busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);

    // First frame after reset: the 16th clock is the first LOAD.
    frame_en = 1'b1;
    base     = tot_px;
    d0       = done_cnt;
    reset    = 1'b0;
    wait_busy(40, n);
    check("first_load_cycle", 64'(n), 64'd16);
    frame_en = 1'b0;
    wait_done(3000);
    check_frame(base, d0, "first");
    check("first_pix0_green", 64'(cap_pix[base]), 64'h00FF00);

    for (int i = 0; i < 7; i++) begin
      if (i == 0 || tbl[i].b0 != tbl[i-1].b0 || tbl[i].b1 != tbl[i-1].b1 ||
          tbl[i].c0 != tbl[i-1].c0 || tbl[i].c1 != tbl[i-1].c1) begin
        rom_bits[0]  = tbl[i].b0;
        rom_bits[1]  = tbl[i].b1;
        rom_color[0] = tbl[i].c0;
        rom_color[1] = tbl[i].c1;
        run_frame(base, $sformatf("tbl%0d", i));
      end
      check($sformatf("tbl%0d_probe_pix", i), 64'(cap_pix[base + tbl[i].k]), 64'(tbl[i].exp_pix));
      check($sformatf("tbl%0d_probe_latch", i), 64'(cap_latch[base + tbl[i].k]), 64'(tbl[i].exp_latch));
    end

    for (int r = 0; r < 4; r++) begin
      hold_len = $urandom_range(1, 6);
      for (int s = 0; s < NC; s++) begin
        rom_bits[s]  = 35'({$urandom(), $urandom()});
        rom_color[s] = 24'($urandom());
      end
      run_frame(base, $sformatf("rand%0d", r));
    end
    hold_len = 5;

    // frame_en dropped mid-frame: the frame still finishes, nothing follows.
    frame_en = 1'b1;
    d0       = done_cnt;
    base     = tot_px;
    wait_busy(40, n);
    wait_px(base, 20, 2000);
    frame_en = 1'b0;
    wait_done(3000);
    check_frame(base, d0, "en_drop");
    busy_seen = 0;
    repeat (100) begin
      step();
      if (frame_busy) busy_seen = busy_seen + 1;
    end
    check("en_drop_no_new_frame", 64'(busy_seen), 64'd0);

    // Long ready stall: the owed frame starts right after frame_done, and only one.
    frame_en = 1'b1;
    d0       = done_cnt;
    base     = tot_px;
    wait_busy(40, n);
    wait_px(base, 10, 2000);
    stall = 1'b1;
    repeat (200) step();
    stall = 1'b0;
    wait_done(4000);
    check("stall_idle_gap", 64'(frame_busy), 64'd0);
    check_frame(base, d0, "stall");
    b2 = tot_px;
    step();
    check("stall_restart_now", 64'(frame_busy), 64'd1);
    frame_en = 1'b0;
    wait_done(3000);
    check("stall_2nd_npix", 64'(tot_px - b2), 64'(TOT));
    busy_seen = 0;
    repeat (100) begin
      step();
      if (frame_busy) busy_seen = busy_seen + 1;
    end
    check("stall_no_third_frame", 64'(busy_seen), 64'd0);
    check("stall_done_total", 64'(done_cnt - d0), 64'd2);

    // Reset in the middle of a frame.
    rom_bits[0]  = 35'h155555555;
    rom_bits[1]  = 35'h2AAAAAAAA;
    rom_color[0] = 24'h102030;
    rom_color[1] = 24'hC0FFEE;
    frame_en = 1'b1;
    base     = tot_px;
    wait_busy(40, n);
    wait_px(base, 40, 2000);
    reset = 1'b1;
    #1;
    check("midrst_pix_valid", 64'(pix_valid), 64'd0);
    check("midrst_pix_data", 64'(pix_data), 64'd0);
    check("midrst_pix_latch", 64'(pix_latch), 64'd0);
    check("midrst_char_slot", 64'(char_slot), 64'd0);
    check("midrst_frame_busy", 64'(frame_busy), 64'd0);
    repeat (3) step();
    base  = tot_px;
    d0    = done_cnt;
    reset = 1'b0;
    wait_busy(40, n);
    check("midrst_restart_cycle", 64'(n), 64'd16);
    frame_en = 1'b0;
    wait_done(3000);
    check_frame(base, d0, "after_rst");

`ifdef STRIP_DIM_EN
    rom_bits[0]  = 35'h7FFFFFFFF;
    rom_bits[1]  = 35'h0;
    rom_color[0] = 24'hF08010;
    rom_color[1] = 24'h000000;
    dim_shift    = 3'd3;
    run_frame(base, "dim");
    check("dim_pix0", 64'(cap_pix[base]), 64'h1E1002);
    dim_shift = 3'd0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
